// File: rtl/spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_sequencer
//  Description : Frame scheduler between the host command list and the SPI
//                sensor shifter. Issues the stored command list once per
//                sample frame, tags each response with its list index,
//                paces frames with a minimum period and flags overruns.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_sequencer #(
    parameter int  CMD_DEPTH = 32,
    parameter int  CMD_W     = 16,
    parameter int  CNT_W     = 16,
    localparam int AW        = $clog2(CMD_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [CMD_W-1:0] cfg_data,
    input  logic [AW:0]      cfg_len,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_frames,
    input  logic             start,
    input  logic             stop,
    output logic             spi_cmd_valid,
    output logic [CMD_W-1:0] spi_cmd_data,
    input  logic             spi_cmd_ready,
    input  logic             spi_rsp_valid,
    input  logic [CMD_W-1:0] spi_rsp_data,
    output logic             rsp_valid,
    output logic [CMD_W-1:0] rsp_data,
    output logic [AW-1:0]    rsp_index,
    output logic             rsp_last,
    output logic             frame_strobe,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ISSUE       = 2'd1,
        S_WAIT_RSP    = 2'd2,
        S_WAIT_PERIOD = 2'd3
    } state_t;

    state_t           r_state;
    logic [CMD_W-1:0] r_list [CMD_DEPTH];
    logic [AW-1:0]    r_idx;
    logic [AW:0]      r_len;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_frames;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_frame_count;
    logic             r_stop_pending;
    logic             r_overrun;
    logic             r_busy;
    logic             r_frame_strobe;
    logic             r_cmd_valid;
    logic [CMD_W-1:0] r_cmd_data;
    logic             r_rsp_valid;
    logic [CMD_W-1:0] r_rsp_data;
    logic [AW-1:0]    r_rsp_index;
    logic             r_rsp_last;

    logic [AW-1:0]    w_idx_next;
    logic [CNT_W-1:0] w_period_thr;
    logic             w_period_done;
    logic             w_last;
    logic             w_list_done;
    logic             w_frame_end;
    logic             w_finish;

    assign w_idx_next    = r_idx + AW'(1);
    // Periods of 0 and 1 both collapse to a threshold of 0 (back-to-back frames).
    assign w_period_thr  = (r_period == '0) ? '0 : r_period - 1'b1;
    assign w_period_done = (r_period_cnt >= w_period_thr);
    assign w_last        = ({1'b0, r_idx} == (r_len - 1'b1));
    assign w_list_done   = (r_state == S_WAIT_RSP) && spi_rsp_valid && w_last;
    // A list that finishes at or past the threshold ends the frame immediately,
    // skipping WAIT_PERIOD, so the next frame starts on the following cycle.
    assign w_frame_end   = (w_list_done && w_period_done) ||
                           ((r_state == S_WAIT_PERIOD) && w_period_done);
    // A stop arriving on the frame-end cycle still counts for this frame.
    assign w_finish      = r_stop_pending || stop ||
                           ((r_frames != '0) && (r_frame_count == r_frames));

    // Command list storage: host writes only while idle, contents survive reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (r_state == S_IDLE)) begin
            r_list[cfg_addr] <= cfg_data;
        end
    end

    // Sequencer FSM with period/frame counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_len          <= '0;
            r_period       <= '0;
            r_frames       <= '0;
            r_period_cnt   <= '0;
            r_frame_count  <= '0;
            r_stop_pending <= 1'b0;
            r_overrun      <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_strobe <= 1'b0;
            r_cmd_valid    <= 1'b0;
            r_cmd_data     <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_index    <= '0;
            r_rsp_last     <= 1'b0;
        end else begin
            r_frame_strobe <= 1'b0;
            r_rsp_valid    <= 1'b0;

            if ((r_state != S_IDLE) && (r_period_cnt != '1)) begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end
            if ((r_state != S_IDLE) && stop) begin
                r_stop_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start && (cfg_len != '0)) begin
                        r_len          <= cfg_len;
                        r_period       <= cfg_period;
                        r_frames       <= cfg_frames;
                        r_overrun      <= 1'b0;
                        r_stop_pending <= 1'b0;
                        r_frame_count  <= CNT_W'(1);
                        r_period_cnt   <= '0;
                        r_idx          <= '0;
                        r_cmd_data     <= r_list[0];
                        r_cmd_valid    <= 1'b1;
                        r_frame_strobe <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (spi_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (spi_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= spi_rsp_data;
                        r_rsp_index <= r_idx;
                        r_rsp_last  <= w_last;
                        if (w_last) begin
                            if (w_period_done) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_state <= S_WAIT_PERIOD;
                            end
                        end else begin
                            r_idx       <= w_idx_next;
                            r_cmd_data  <= r_list[w_idx_next];
                            r_cmd_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    // S_WAIT_PERIOD: frame end handled below
                end
            endcase

            if (w_frame_end) begin
                if (w_finish) begin
                    r_stop_pending <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end else begin
                    r_frame_count  <= r_frame_count + 1'b1;
                    r_period_cnt   <= '0;
                    r_idx          <= '0;
                    r_cmd_data     <= r_list[0];
                    r_cmd_valid    <= 1'b1;
                    r_frame_strobe <= 1'b1;
                    r_state        <= S_ISSUE;
                end
            end
        end
    end

    assign spi_cmd_valid = r_cmd_valid;
    assign spi_cmd_data  = r_cmd_data;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_index     = r_rsp_index;
    assign rsp_last      = r_rsp_last;
    assign frame_strobe  = r_frame_strobe;
    assign busy          = r_busy;
    assign frame_count   = r_frame_count;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_cmd_sequencer
//  Description : Self-checking bench for spi_cmd_sequencer with an SPI
//                shifter model, response scoreboard and frame vector table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_sequencer;

    localparam int CMD_DEPTH = 32;
    localparam int CMD_W     = 16;
    localparam int CNT_W     = 16;
    localparam int AW        = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [CMD_W-1:0] cfg_data;
    logic [AW:0]      cfg_len;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_frames;
    logic             start;
    logic             stop;
    logic             spi_cmd_valid;
    logic [CMD_W-1:0] spi_cmd_data;
    logic             spi_cmd_ready;
    logic             spi_rsp_valid;
    logic [CMD_W-1:0] spi_rsp_data;
    logic             rsp_valid;
    logic [CMD_W-1:0] rsp_data;
    logic [AW-1:0]    rsp_index;
    logic             rsp_last;
    logic             frame_strobe;
    logic             busy;
    logic [CNT_W-1:0] frame_count;
    logic             overrun;

    spi_cmd_sequencer #(
        .CMD_DEPTH (CMD_DEPTH),
        .CMD_W     (CMD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_len       (cfg_len),
        .cfg_period    (cfg_period),
        .cfg_frames    (cfg_frames),
        .start         (start),
        .stop          (stop),
        .spi_cmd_valid (spi_cmd_valid),
        .spi_cmd_data  (spi_cmd_data),
        .spi_cmd_ready (spi_cmd_ready),
        .spi_rsp_valid (spi_rsp_valid),
        .spi_rsp_data  (spi_rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_index     (rsp_index),
        .rsp_last      (rsp_last),
        .frame_strobe  (frame_strobe),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CMD_W-1:0] data;
        int               idx;
        bit               last;
    } exp_t;

    typedef struct {
        int len;
        int period;
        int frames;
        int dly;
        int exp_spacing;
        bit exp_ovr;
    } vec_t;

    exp_t             exp_q[$];
    int               strobe_q[$];
    logic [CMD_W-1:0] tb_list [CMD_DEPTH];
    int               n_vec   = 0;
    int               n_err   = 0;
    int               n_rsp   = 0;
    int               exp_idx = 0;
    int               exp_len = 1;
    int               rsp_dly = 5;
    vec_t             vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Shifter model: accepts a command, answers with its complement after rsp_dly cycles.
    initial begin : shifter
        logic [CMD_W-1:0] c;
        spi_rsp_valid = 1'b0;
        spi_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && spi_cmd_valid && spi_cmd_ready) begin
                chk("cmd_data", spi_cmd_data, tb_list[exp_idx]);
                exp_q.push_back('{tb_list[exp_idx] ^ 16'hFFFF, exp_idx, (exp_idx == exp_len - 1)});
                exp_idx = (exp_idx == exp_len - 1) ? 0 : exp_idx + 1;
                c = spi_cmd_data;
                @(posedge clk); #1;
                repeat (rsp_dly - 1) begin @(posedge clk); #1; end
                spi_rsp_valid = 1'b1;
                spi_rsp_data  = c ^ 16'hFFFF;
                @(posedge clk); #1;
                spi_rsp_valid = 1'b0;
            end
        end
    end

    // Response scoreboard: every tagged response must match the oldest expectation.
    initial begin : rsp_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_index", rsp_index, e.idx);
                    chk("rsp_last", rsp_last, e.last);
                end
            end
        end
    end

    // Frame strobe log (cycle numbers) for spacing checks.
    initial begin : strobe_monitor
        forever begin
            @(negedge clk);
            if (frame_strobe) strobe_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic write_entry(input int a, input logic [CMD_W-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a[AW-1:0];
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic launch(input int len, input int period, input int frames, input int dly);
        cfg_len    = len[AW:0];
        cfg_period = period[CNT_W-1:0];
        cfg_frames = frames[CNT_W-1:0];
        rsp_dly    = dly;
        exp_len    = len;
        exp_idx    = 0;
        n_rsp      = 0;
        strobe_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_strobe", frame_strobe, 1);
        chk("start_cmd_valid", spi_cmd_valid, 1);
        chk("start_overrun_clear", overrun, 0);
        chk("start_frame_count", frame_count, 1);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        chk("idle_timeout", busy, 0);
        repeat (3) tick();
    endtask

    task automatic check_frames(input int frames, input int spacing);
        chk("frames_run", strobe_q.size(), frames);
        for (int i = 1; i < strobe_q.size(); i++) begin
            chk("strobe_spacing", strobe_q[i] - strobe_q[i-1], spacing);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cmd_valid"}, spi_cmd_valid, 0);
        chk({tag, "_cmd_data"}, spi_cmd_data, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, {rsp_data, rsp_index, rsp_last}, 0);
        chk({tag, "_strobe"}, frame_strobe, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin : main
        int k;
        // len, period, frames, rsp delay, expected strobe spacing, expected overrun
        vecs[0] = '{3, 75, 2, 5, 75, 1'b0};  // 18-cycle list inside 75-cycle period
        vecs[1] = '{3, 10, 2, 7, 24, 1'b1};  // 8-cycle commands: list 24 > period 10
        vecs[2] = '{1,  4, 3, 1,  4, 1'b0};  // new start clears previous overrun
        vecs[3] = '{2,  0, 3, 1,  4, 1'b1};  // period 0: back-to-back, always overrun
        vecs[4] = '{2,  7, 2, 2,  7, 1'b0};  // 6-cycle list, one short of period 7
        vecs[5] = '{3, 12, 1, 2,  0, 1'b0};  // single frame
        vecs[6] = '{1,  1, 2, 1,  2, 1'b1};  // period 1 behaves like period 0

        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        cfg_len = '0; cfg_period = '0; cfg_frames = '0;
        start = 1'b0; stop = 1'b0; spi_cmd_ready = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < CMD_DEPTH; i++) tb_list[i] = 16'h8000 + 16'(i << 8);
        for (int i = 0; i < 4; i++) write_entry(i, tb_list[i]);

        // start with zero length is ignored
        cfg_len = '0; start = 1'b1; tick(); start = 1'b0;
        chk("len0_busy", busy, 0);
        chk("len0_cmd_valid", spi_cmd_valid, 0);
        tick();
        chk("len0_busy_later", busy, 0);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            launch(vecs[v].len, vecs[v].period, vecs[v].frames, vecs[v].dly);
            wait_idle(2000);
            check_frames(vecs[v].frames, vecs[v].exp_spacing);
            chk("frame_count", frame_count, vecs[v].frames);
            chk("overrun", overrun, vecs[v].exp_ovr);
            chk("rsp_count", n_rsp, vecs[v].len * vecs[v].frames);
            chk("sb_empty", exp_q.size(), 0);
        end

        // Continuous mode stopped during the third frame
        launch(1, 20, 0, 3);
        k = 0;
        while (strobe_q.size() < 3 && k < 300) begin tick(); k++; end
        chk("cont_strobe_wait", (strobe_q.size() >= 3), 1);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_idle(300);
        check_frames(3, 20);
        chk("cont_rsp_count", n_rsp, 3);
        repeat (50) tick();
        chk("cont_no_strobe_after_stop", strobe_q.size(), 3);
        chk("cont_busy", busy, 0);

        // start and cfg_we while busy are ignored
        launch(3, 75, 2, 5);
        k = 0;
        while (strobe_q.size() < 2 && k < 300) begin tick(); k++; end
        chk("busy_strobe_wait", strobe_q.size(), 2);
        write_entry(0, 16'hDEAD);
        cfg_len = 6'd1; start = 1'b1; tick(); start = 1'b0;
        chk("restart_strobe", frame_strobe, 0);
        chk("restart_frame_count", frame_count, 2);
        wait_idle(2000);
        check_frames(2, 75);
        chk("restart_rsp_count", n_rsp, 6);
        launch(1, 5, 1, 2);
        wait_idle(200);
        chk("list_kept_rsp_count", n_rsp, 1);

        // Ready held low for 20 cycles
        spi_cmd_ready = 1'b0;
        launch(1, 30, 1, 2);
        for (int i = 0; i < 20; i++) begin
            chk("hold_cmd_valid", spi_cmd_valid, 1);
            chk("hold_cmd_data", spi_cmd_data, tb_list[0]);
            tick();
        end
        spi_cmd_ready = 1'b1;
        tick();
        chk("drop_after_accept", spi_cmd_valid, 0);
        wait_idle(200);
        chk("hold_rsp_count", n_rsp, 1);

        // Reset during WAIT_RSP
        launch(3, 75, 1, 5);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        exp_q.delete();
        n_rsp = 0;
        check_outputs_zero("midreset");
        repeat (10) tick();
        chk("late_rsp_dropped", n_rsp, 0);
        launch(vecs[0].len, vecs[0].period, vecs[0].frames, vecs[0].dly);
        wait_idle(2000);
        check_frames(2, 75);
        chk("post_reset_rsp_count", n_rsp, 6);
        chk("post_reset_frame_count", frame_count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
